// File: rtl/bus_interconnect_n.sv
// Parametrised 68k bus interconnect: base/mask address decode, strobe and
// data routing, held DTACK-style acknowledge, watchdog and unmapped bus error.
module bus_interconnect_n #(
    parameter int                        NUM_SLAVES = 4,
    parameter int                        SLV_AW     = 8,
    parameter logic [NUM_SLAVES*32-1:0] BASE       = {32'h00F2_0000, 32'h00F1_0000,
                                                      32'h00F0_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] MASK       = {NUM_SLAVES{32'h00FF_0000}},
    parameter int                        TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              master_addr,
    input  logic [15:0]              master_write,
    output logic [15:0]              master_read,
    input  logic                     master_uds,
    input  logic                     master_lds,
    input  logic                     master_rw,
    output logic                     master_ack,
    output logic                     master_berr,
    output logic [NUM_SLAVES-1:0]    slave_sel,
    output logic [SLV_AW-1:0]        slave_addr,
    output logic [15:0]              slave_write,
    output logic [NUM_SLAVES-1:0]    slave_uds,
    output logic [NUM_SLAVES-1:0]    slave_lds,
    output logic                     slave_rw,
    input  logic [NUM_SLAVES*16-1:0] slave_read,
    input  logic [NUM_SLAVES-1:0]    slave_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [SLV_AW-1:0]       addr_q, addr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [15:0]             read_q, read_d;
    logic                    ack_q, ack_d;
    logic                    berr_q, berr_d;

    logic                    strobe;
    logic                    hit_any;
    logic [IW-1:0]           hit_idx;
    logic                    cur_ack;
    logic [15:0]             cur_rdata;

    wire unused_addr_hi = ^master_addr[31:24];

    assign strobe = master_uds | master_lds;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((master_addr[23:0] & MASK[i*32 +: 24]) == BASE[i*32 +: 24]) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Only the registered target's ack and data are visible.
    always_comb begin
        cur_ack   = 1'b0;
        cur_rdata = 16'h0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IW'(i)) begin
                cur_ack   = slave_ack[i];
                cur_rdata = slave_read[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        read_d  = read_q;
        ack_d   = ack_q;
        berr_d  = berr_q;
        unique case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    if (hit_any) begin
                        state_d = S_ACCESS;
                        idx_d   = hit_idx;
                        sel_d   = NUM_SLAVES'(1) << hit_idx;
                        addr_d  = master_addr[SLV_AW-1:0];
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERR;
                        berr_d  = 1'b1;
                        read_d  = 16'h0000;
                    end
                end
            end
            S_ACCESS: begin
                if (!strobe) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end else if (cur_ack) begin
                    state_d = S_DONE;
                    read_d  = cur_rdata;
                    ack_d   = 1'b1;
                    sel_d   = '0;
                end else if (cnt_q == TMAX) begin
                    state_d = S_ERR;
                    berr_d  = 1'b1;
                    read_d  = 16'h0000;
                    sel_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!strobe) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                end
            end
            S_ERR: begin
                if (!strobe) begin
                    state_d = S_IDLE;
                    berr_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            read_q  <= 16'h0000;
            ack_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            read_q  <= read_d;
            ack_q   <= ack_d;
            berr_q  <= berr_d;
        end
    end

    assign master_read = read_q;
    assign master_ack  = ack_q;
    assign master_berr = berr_q;
    assign slave_sel   = sel_q;
    assign slave_addr  = addr_q;
    assign slave_write = master_write;
    assign slave_rw    = master_rw;
    assign slave_uds   = {NUM_SLAVES{master_uds}} & sel_q;
    assign slave_lds   = {NUM_SLAVES{master_lds}} & sel_q;

endmodule

// File: tb/tb_bus_interconnect_n.sv
// Directed bench for bus_interconnect_n; responses are checked by a
// scoreboard monitor against expectations queued by the stimulus.
module tb_bus_interconnect_n;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] master_addr;
    logic [15:0] master_write;
    logic [15:0] master_read;
    logic        master_uds;
    logic        master_lds;
    logic        master_rw;
    logic        master_ack;
    logic        master_berr;
    logic [3:0]  slave_sel;
    logic [7:0]  slave_addr;
    logic [15:0] slave_write;
    logic [3:0]  slave_uds;
    logic [3:0]  slave_lds;
    logic        slave_rw;
    logic [63:0] slave_read;
    logic [3:0]  slave_ack;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        berr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    logic p_ack  = 1'b0;
    logic p_berr = 1'b0;

    always #5 clk = ~clk;

    bus_interconnect_n #(
        .NUM_SLAVES(4),
        .SLV_AW    (8),
        .BASE      ({32'h00F2_0000, 32'h00F1_0000, 32'h00F1_0000, 32'h0000_0000}),
        .MASK      ({4{32'h00FF_0000}}),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .master_addr (master_addr),
        .master_write(master_write),
        .master_read (master_read),
        .master_uds  (master_uds),
        .master_lds  (master_lds),
        .master_rw   (master_rw),
        .master_ack  (master_ack),
        .master_berr (master_berr),
        .slave_sel   (slave_sel),
        .slave_addr  (slave_addr),
        .slave_write (slave_write),
        .slave_uds   (slave_uds),
        .slave_lds   (slave_lds),
        .slave_rw    (slave_rw),
        .slave_read  (slave_read),
        .slave_ack   (slave_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (master_ack && master_berr) begin
                total++;
                bad++;
                $display("FAIL ack_berr_excl: ack=%b berr=%b want not both", master_ack, master_berr);
            end
            if ((master_ack && !p_ack) || (master_berr && !p_berr)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: ack=%b berr=%b want none", master_ack, master_berr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_berr", {31'b0, master_berr}, {31'b0, e.berr});
                    chk("resp_ack", {31'b0, master_ack}, {31'b0, ~e.berr});
                    chk("resp_data", {16'b0, master_read}, {16'b0, e.data});
                end
            end
        end
        p_ack  <= master_ack;
        p_berr <= master_berr;
    end

    initial begin
        int rise;
        reset_n      = 1'b0;
        master_addr  = '0;
        master_write = '0;
        master_uds   = 1'b0;
        master_lds   = 1'b0;
        master_rw    = 1'b1;
        slave_read   = '0;
        slave_ack    = '0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_sel", {28'b0, slave_sel}, 32'h0);
        chk("rst_addr", {24'b0, slave_addr}, 32'h0);
        chk("rst_read", {16'b0, master_read}, 32'h0);
        chk("rst_ack", {31'b0, master_ack}, 32'h0);
        chk("rst_berr", {31'b0, master_berr}, 32'h0);

        // read from slave 0, ack two cycles after select
        master_addr = 32'h0000_0010;
        master_rw   = 1'b1;
        master_uds  = 1'b1;
        master_lds  = 1'b1;
        sb.push_back('{1'b0, 16'hBEEF});
        tick();
        chk("rd_sel", {28'b0, slave_sel}, 32'h1);
        chk("rd_addr", {24'b0, slave_addr}, 32'h10);
        chk("rd_uds", {28'b0, slave_uds}, 32'h1);
        chk("rd_ack_early", {31'b0, master_ack}, 32'h0);
        tick();
        slave_read[15:0] = 16'hBEEF;
        slave_ack        = 4'b0001;
        tick();
        slave_ack = 4'b0000;
        chk("rd_ack", {31'b0, master_ack}, 32'h1);
        chk("rd_sel_clr", {28'b0, slave_sel}, 32'h0);
        tick();
        chk("rd_ack_hold", {31'b0, master_ack}, 32'h1);
        chk("rd_data_hold", {16'b0, master_read}, 32'hBEEF);
        master_uds = 1'b0;
        master_lds = 1'b0;
        tick();
        chk("rd_ack_drop", {31'b0, master_ack}, 32'h0);

        // lower-byte write to slave 3, stray ack from slave 0 ignored
        master_addr        = 32'h00F2_0003;
        master_rw          = 1'b0;
        master_lds         = 1'b1;
        master_write       = 16'h00A5;
        slave_read[63:48]  = 16'h5A5A;
        sb.push_back('{1'b0, 16'h5A5A});
        tick();
        chk("wr_sel", {28'b0, slave_sel}, 32'h8);
        chk("wr_lds", {28'b0, slave_lds}, 32'h8);
        chk("wr_uds", {28'b0, slave_uds}, 32'h0);
        chk("wr_rw", {31'b0, slave_rw}, 32'h0);
        chk("wr_data", {16'b0, slave_write}, 32'h00A5);
        chk("wr_addr", {24'b0, slave_addr}, 32'h03);
        slave_ack = 4'b0001;
        tick();
        chk("wr_stray_ack", {31'b0, master_ack}, 32'h0);
        chk("wr_sel_kept", {28'b0, slave_sel}, 32'h8);
        slave_ack = 4'b1000;
        tick();
        slave_ack = 4'b0000;
        chk("wr_ack", {31'b0, master_ack}, 32'h1);
        master_lds = 1'b0;
        tick();
        chk("wr_ack_drop", {31'b0, master_ack}, 32'h0);

        // unmapped access
        master_addr = 32'h0080_0000;
        master_rw   = 1'b1;
        master_uds  = 1'b1;
        master_lds  = 1'b1;
        sb.push_back('{1'b1, 16'h0000});
        tick();
        chk("um_berr", {31'b0, master_berr}, 32'h1);
        chk("um_sel", {28'b0, slave_sel}, 32'h0);
        chk("um_read", {16'b0, master_read}, 32'h0);
        tick();
        chk("um_berr_hold", {31'b0, master_berr}, 32'h1);
        chk("um_sel_hold", {28'b0, slave_sel}, 32'h0);
        master_uds = 1'b0;
        master_lds = 1'b0;
        tick();
        chk("um_berr_drop", {31'b0, master_berr}, 32'h0);

        // overlap resolves to slave 1, which never acks
        master_addr = 32'h00F1_0004;
        master_uds  = 1'b1;
        sb.push_back('{1'b1, 16'h0000});
        tick();
        chk("ov_sel", {28'b0, slave_sel}, 32'h2);
        rise = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (master_berr && rise == 0) rise = k;
        end
        chk("to_rise_cycle", rise, 8);
        chk("to_sel_clr", {28'b0, slave_sel}, 32'h0);
        slave_ack = 4'b0010;
        tick();
        slave_ack = 4'b0000;
        chk("to_late_ack", {31'b0, master_ack}, 32'h0);
        chk("to_berr_hold", {31'b0, master_berr}, 32'h1);
        master_uds = 1'b0;
        tick();
        chk("to_berr_drop", {31'b0, master_berr}, 32'h0);

        // ack on the final cycle wins over the timeout
        master_uds        = 1'b1;
        slave_read[31:16] = 16'h1111;
        sb.push_back('{1'b0, 16'h1111});
        tick();
        repeat (7) tick();
        chk("to8_no_berr_yet", {31'b0, master_berr}, 32'h0);
        slave_ack = 4'b0010;
        tick();
        slave_ack = 4'b0000;
        chk("to8_ack", {31'b0, master_ack}, 32'h1);
        chk("to8_berr", {31'b0, master_berr}, 32'h0);
        master_uds = 1'b0;
        tick();

        // aborted cycle
        master_addr = 32'h0000_0020;
        master_uds  = 1'b1;
        master_lds  = 1'b1;
        tick();
        chk("ab_sel", {28'b0, slave_sel}, 32'h1);
        master_uds = 1'b0;
        master_lds = 1'b0;
        tick();
        chk("ab_sel_clr", {28'b0, slave_sel}, 32'h0);
        chk("ab_ack", {31'b0, master_ack}, 32'h0);
        chk("ab_berr", {31'b0, master_berr}, 32'h0);
        tick();

        // reset in the middle of an access
        master_addr = 32'h0000_0030;
        master_uds  = 1'b1;
        tick();
        chk("mr_sel", {28'b0, slave_sel}, 32'h1);
        chk("mr_addr", {24'b0, slave_addr}, 32'h30);
        reset_n    = 1'b0;
        master_uds = 1'b0;
        tick();
        chk("mr_sel_rst", {28'b0, slave_sel}, 32'h0);
        chk("mr_addr_rst", {24'b0, slave_addr}, 32'h0);
        chk("mr_read_rst", {16'b0, master_read}, 32'h0);
        chk("mr_ack_rst", {31'b0, master_ack}, 32'h0);
        chk("mr_berr_rst", {31'b0, master_berr}, 32'h0);
        reset_n = 1'b1;
        tick();

        // normal transfer after reset
        master_addr      = 32'h0000_0044;
        master_lds       = 1'b1;
        slave_read[15:0] = 16'hCAFE;
        sb.push_back('{1'b0, 16'hCAFE});
        tick();
        chk("pr_addr", {24'b0, slave_addr}, 32'h44);
        slave_ack = 4'b0001;
        tick();
        slave_ack = 4'b0000;
        chk("pr_ack", {31'b0, master_ack}, 32'h1);
        chk("pr_data", {16'b0, master_read}, 32'hCAFE);
        master_lds = 1'b0;
        tick();
        chk("pr_ack_drop", {31'b0, master_ack}, 32'h0);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
